// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM frame-command arbiter: command codes, FSM states, port ids.
// Pure declarations; no logic or latency of its own.
// No backpressure behaviour; consumed by ram_cmd_arbiter and ram_arb_timer users.
package ram_arb_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_2ND = 2'd1,
        WAIT_RD  = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    // Address frames (00, 10) open a transaction; data frames (01, 11) close or continue it.
    function automatic logic is_first(input logic [1:0] cmd);
        return ~cmd[0];
    endfunction

endpackage

// File: rtl/ram_arb_timer.sv
// Loadable down-counter that flags when a held lock has been idle for the loaded number of cycles.
// expire is combinational from the count register; load takes effect on the next edge.
// No backpressure; load has priority over clear, clear over counting.
module ram_arb_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             run,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // The last idle cycle is the one in which the count reads 1.
    assign expire = run && (cnt == WIDTH'(1));

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Per-transaction arbiter sharing the RAM frame port between port A and port B; optional lock timeout under ARB_TIMEOUT_EN.
// Frame to RAM and read data to owner are registered: one cycle after acceptance / ram_tx_valid.
// Ready is combinational: both ready in IDLE (tie loser held), only owner in WAIT_2ND, none in WAIT_RD.
module ram_cmd_arbiter
    import ram_arb_pkg::*;
#(
    parameter int FRAME_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_valid,
    input  logic [FRAME_WIDTH+1:0] a_data,
    output logic                   a_ready,
    output logic                   a_tx_valid,
    output logic [FRAME_WIDTH-1:0] a_tx_data,
    input  logic                   b_valid,
    input  logic [FRAME_WIDTH+1:0] b_data,
    output logic                   b_ready,
    output logic                   b_tx_valid,
    output logic [FRAME_WIDTH-1:0] b_tx_data,
    output logic                   ram_rx_valid,
    output logic [FRAME_WIDTH+1:0] ram_din,
    input  logic                   ram_tx_valid,
    input  logic [FRAME_WIDTH-1:0] ram_dout,
    output logic                   busy,
    output logic                   err
);

    localparam int CW = FRAME_WIDTH + 2;

    arb_state_t state;
    port_id_t   owner;
    port_id_t   last_grant;

    logic          a_first, b_first, a_acc, b_acc;
    logic          tie, a_wins_tie, grant_any, own_acc, timeout;
    logic [CW-1:0] own_frame;
    logic [1:0]    own_cmd;

    assign a_first    = a_valid && is_first(a_data[CW-1:FRAME_WIDTH]);
    assign b_first    = b_valid && is_first(b_data[CW-1:FRAME_WIDTH]);
    assign tie        = a_first && b_first;
    assign a_wins_tie = (last_grant == PORT_B);

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        unique case (state)
            IDLE: begin
                a_ready = !(tie && !a_wins_tie);
                b_ready = !(tie && a_wins_tie);
            end
            WAIT_2ND: begin
                a_ready = (owner == PORT_A);
                b_ready = (owner == PORT_B);
            end
            default: ;
        endcase
    end

    assign a_acc     = a_valid && a_ready;
    assign b_acc     = b_valid && b_ready;
    assign grant_any = (a_acc && a_first) || (b_acc && b_first);
    assign own_acc   = (owner == PORT_A) ? a_acc : b_acc;
    assign own_frame = (owner == PORT_A) ? a_data : b_data;
    assign own_cmd   = own_frame[CW-1:FRAME_WIDTH];

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES);

    logic timer_load;

    // Every frame from the owner restarts the idle window, including the one that enters WAIT_RD.
    assign timer_load = ((state == IDLE) && grant_any) || ((state == WAIT_2ND) && own_acc);

    ram_arb_timer #(
        .WIDTH(16)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .clear      (state == IDLE),
        .run        (state != IDLE),
        .load_value (TIMEOUT_LOAD),
        .expire     (timeout)
    );
`else
    // Without the timer the lock never expires; the parameter stays for interface compatibility.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= PORT_A;
            last_grant   <= PORT_B;
            ram_rx_valid <= 1'b0;
            ram_din      <= '0;
            a_tx_valid   <= 1'b0;
            a_tx_data    <= '0;
            b_tx_valid   <= 1'b0;
            b_tx_data    <= '0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            ram_rx_valid <= 1'b0;
            a_tx_valid   <= 1'b0;
            b_tx_valid   <= 1'b0;
            err          <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (a_acc && a_first) begin
                        ram_rx_valid <= 1'b1;
                        ram_din      <= a_data;
                        owner        <= PORT_A;
                        state        <= WAIT_2ND;
                        busy         <= 1'b1;
                    end else if (b_acc && b_first) begin
                        ram_rx_valid <= 1'b1;
                        ram_din      <= b_data;
                        owner        <= PORT_B;
                        state        <= WAIT_2ND;
                        busy         <= 1'b1;
                    end
                    // Orphaned data frames are swallowed so a confused requester cannot stall.
                    if ((a_acc && !a_first) || (b_acc && !b_first)) begin
                        err <= 1'b1;
                    end
                end
                WAIT_2ND: begin
                    if (own_acc) begin
                        ram_rx_valid <= 1'b1;
                        ram_din      <= own_frame;
                        case (own_cmd)
                            CMD_WR_DATA: begin
                                state      <= IDLE;
                                busy       <= 1'b0;
                                last_grant <= owner;
                            end
                            CMD_RD_DATA: state <= WAIT_RD;
                            default:     state <= WAIT_2ND;
                        endcase
                    end else if (timeout) begin
                        err        <= 1'b1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                        last_grant <= owner;
                    end
                end
                WAIT_RD: begin
                    if (ram_tx_valid) begin
                        if (owner == PORT_A) begin
                            a_tx_valid <= 1'b1;
                            a_tx_data  <= ram_dout;
                        end else begin
                            b_tx_valid <= 1'b1;
                            b_tx_data  <= ram_dout;
                        end
                        state      <= IDLE;
                        busy       <= 1'b0;
                        last_grant <= owner;
                    end else if (timeout) begin
                        err        <= 1'b1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                        last_grant <= owner;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Scoreboard bench for ram_cmd_arbiter: expected RAM frames, read returns and err pulses are queued
// with their expected cycle when stimulus is driven and matched when the DUT produces them.
module tb_ram_cmd_arbiter;

    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic [FW+1:0] a_data = '0, b_data = '0;
    logic          a_ready, b_ready, a_tx_valid, b_tx_valid;
    logic [FW-1:0] a_tx_data, b_tx_data;
    logic          ram_rx_valid;
    logic [FW+1:0] ram_din;
    logic          ram_tx_valid = 1'b0;
    logic [FW-1:0] ram_dout = '0;
    logic          busy, err;

    ram_cmd_arbiter #(.FRAME_WIDTH(FW), .TIMEOUT_CYCLES(255)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .a_tx_valid   (a_tx_valid),
        .a_tx_data    (a_tx_data),
        .b_valid      (b_valid),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .b_tx_valid   (b_tx_valid),
        .b_tx_data    (b_tx_data),
        .ram_rx_valid (ram_rx_valid),
        .ram_din      (ram_din),
        .ram_tx_valid (ram_tx_valid),
        .ram_dout     (ram_dout),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] dat;
    } exp_t;

    exp_t ram_q[$];
    exp_t a_q[$];
    exp_t b_q[$];
    int   err_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int c, input logic [31:0] d);
        exp_t e;
        e.cyc = c;
        e.dat = d;
        return e;
    endfunction

    // Called at negedge+1 of the cycle whose closing edge accepts the frame.
    task automatic push_ram(input logic [FW+1:0] f);
        ram_q.push_back(mk(cyc + 1, 32'(f)));
    endtask

    // Output monitor, sampling away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (ram_rx_valid) begin
            if (ram_q.size() == 0) check("ram_rx_unexpected", ram_rx_valid, 1'b0);
            else begin
                e = ram_q.pop_front();
                check("ram_din", 32'(ram_din), e.dat);
                check("ram_din_cycle", cyc, e.cyc);
            end
        end
        if (a_tx_valid) begin
            if (a_q.size() == 0) check("a_tx_unexpected", a_tx_valid, 1'b0);
            else begin
                e = a_q.pop_front();
                check("a_tx_data", 32'(a_tx_data), e.dat);
                check("a_tx_cycle", cyc, e.cyc);
            end
        end
        if (b_tx_valid) begin
            if (b_q.size() == 0) check("b_tx_unexpected", b_tx_valid, 1'b0);
            else begin
                e = b_q.pop_front();
                check("b_tx_data", 32'(b_tx_data), e.dat);
                check("b_tx_cycle", cyc, e.cyc);
            end
        end
        if (err) begin
            if (err_q.size() == 0) check("err_unexpected", err, 1'b0);
            else check("err_cycle", cyc, err_q.pop_front());
        end
    end

    task automatic send(input bit port_b, input logic [FW+1:0] frame, input bit fwd, input bit exp_err);
        logic rdy;
        @(negedge clk);
        if (port_b) begin b_valid = 1'b1; b_data = frame; end
        else        begin a_valid = 1'b1; a_data = frame; end
        #1;
        rdy = port_b ? b_ready : a_ready;
        for (int i = 0; i < 50 && !rdy; i++) begin
            @(negedge clk);
            #1;
            rdy = port_b ? b_ready : a_ready;
        end
        check("send_ready", rdy, 1'b1);
        if (rdy && fwd) push_ram(frame);
        if (rdy && exp_err) err_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        if (port_b) b_valid = 1'b0;
        else        a_valid = 1'b0;
    endtask

    task automatic ram_return(input logic [FW-1:0] d, input bit port_b, input bit exp);
        @(negedge clk);
        ram_tx_valid = 1'b1;
        ram_dout     = d;
        if (exp) begin
            if (port_b) b_q.push_back(mk(cyc + 1, 32'(d)));
            else        a_q.push_back(mk(cyc + 1, 32'(d)));
        end
        @(negedge clk);
        ram_tx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_a_ready"}, a_ready, 1'b1);
        check({pfx, "_b_ready"}, b_ready, 1'b1);
        check({pfx, "_busy"}, busy, 1'b0);
        check({pfx, "_err"}, err, 1'b0);
        check({pfx, "_ram_rx_valid"}, ram_rx_valid, 1'b0);
        check({pfx, "_ram_din"}, 32'(ram_din), 32'h0);
        check({pfx, "_a_tx"}, {a_tx_valid, a_tx_data}, 32'h0);
        check({pfx, "_b_tx"}, {b_tx_valid, b_tx_data}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic seen;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("reset");

        // Write pair from A
        send(0, 10'h012, 1, 0);
        check("wr_busy_locked", busy, 1'b1);
        send(0, 10'h134, 1, 0);
        check("wr_busy_done", busy, 1'b0);

        // Read from B; A must see nothing
        send(1, 10'h212, 1, 0);
        send(1, 10'h300, 1, 0);
        @(negedge clk); #1;
        check("rd_busy_wait", busy, 1'b1);
        ram_return(8'h5A, 1, 1);
        repeat (2) @(negedge clk);
        check("rd_busy_done", busy, 1'b0);

        // Stray read data in IDLE is dropped
        ram_return(8'hC3, 0, 0);

        // Contention: A wins first tie, B wins the next one
        @(negedge clk);
        a_valid = 1'b1; a_data = 10'h011; b_valid = 1'b1; b_data = 10'h022; #1;
        check("tie1_a_ready", a_ready, 1'b1);
        check("tie1_b_ready", b_ready, 1'b0);
        push_ram(10'h011);
        @(negedge clk); a_data = 10'h133; #1;
        check("lockA_b_ready", b_ready, 1'b0);
        check("lockA_a_ready", a_ready, 1'b1);
        push_ram(10'h133);
        @(negedge clk); a_data = 10'h055; #1;
        check("tie2_a_ready", a_ready, 1'b0);
        check("tie2_b_ready", b_ready, 1'b1);
        push_ram(10'h022);
        @(negedge clk); b_data = 10'h144; #1;
        check("lockB_a_ready", a_ready, 1'b0);
        push_ram(10'h144);
        @(negedge clk); b_valid = 1'b0; #1;
        check("after_a_ready", a_ready, 1'b1);
        push_ram(10'h055);
        @(negedge clk); a_data = 10'h166; #1;
        push_ram(10'h166);
        @(negedge clk); a_valid = 1'b0;

        // Orphan alone, then orphan alongside a first frame
        @(negedge clk); b_valid = 1'b1; b_data = 10'h1AA; #1;
        check("orphan_b_ready", b_ready, 1'b1);
        err_q.push_back(cyc + 1);
        @(posedge clk); #1; b_valid = 1'b0;
        @(negedge clk); #1;
        check("orphan_busy", busy, 1'b0);
        a_valid = 1'b1; a_data = 10'h0C1; b_valid = 1'b1; b_data = 10'h1BB; #1;
        check("mix_a_ready", a_ready, 1'b1);
        check("mix_b_ready", b_ready, 1'b1);
        push_ram(10'h0C1);
        err_q.push_back(cyc + 1);
        @(posedge clk); #1; a_valid = 1'b0; b_valid = 1'b0;
        send(0, 10'h1C2, 1, 0);

        // Idle lock: A opens a write and goes silent while B waits
        send(0, 10'h005, 1, 0);
        t0 = cyc;
        @(negedge clk); b_valid = 1'b1; b_data = 10'h2AA; #1;
`ifdef ARB_TIMEOUT_EN
        err_q.push_back(t0 + 255);
        for (int i = 0; i < 400 && !b_ready; i++) begin
            @(negedge clk); #1;
        end
        check("timeout_release_cycle", cyc - t0, 255);
        check("timeout_busy", busy, 1'b0);
`else
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk); #1;
            if (b_ready || !busy) seen = 1'b1;
        end
        check("nolimit_lock_held", seen, 1'b0);
        b_valid = 1'b1;
        send(0, 10'h105, 1, 0);
        @(negedge clk); #1;
`endif
        check("pending_b_ready", b_ready, 1'b1);
        push_ram(10'h2AA);
        @(posedge clk); #1; b_valid = 1'b0;
        send(1, 10'h3AA, 1, 0);
        ram_return(8'h11, 1, 1);

        // Reset while a read is in flight; the late read data must go nowhere
        send(0, 10'h212, 1, 0);
        send(0, 10'h300, 1, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        check_reset_outputs("midrst");
        ram_return(8'h77, 0, 0);
        repeat (4) @(negedge clk);

        check("ram_q_drained", ram_q.size(), 0);
        check("a_q_drained", a_q.size(), 0);
        check("b_q_drained", b_q.size(), 0);
        check("err_q_drained", err_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
